dmem_mmio: RTL and testbench
============================

# dmem_mmio

Data-memory responder for the single-clock RV32 core's data port. The core drives address, write strobe and write data and expects read data back combinationally in the same cycle. This block serves that data port with a word-addressed RAM plus a small memory-mapped I/O window. The window holds a GPIO output register and a compare timer that raises an interrupt line.

## Interface
- XLEN, 32, data/address width
- DEPTH, 256, RAM size in 32-bit words (power of two)
- MMIO_BASE, 32'h8000_0000, base address of the I/O window (4 KiB aligned)

- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset, asynchronous, active-low
- mem_we_i  input  1  write strobe from the core
- mem_addr_i  input  XLEN  byte address from the core
- mem_data_i  input  XLEN  write data from the core
- mem_data_o  output  XLEN  read data to the core, combinational
- gpio_o  output  XLEN  GPIO output register
- irq_o  output  1  timer interrupt, registered level

## Operation
- Address decode:
  - mem_addr_i < MMIO_BASE selects RAM.
  - mem_addr_i[31:12] == MMIO_BASE[31:12] selects MMIO.
  - Any other address is unmapped: reads return 0 and writes are ignored.
- Bits [1:0] of the address are ignored. All accesses are full-word.
- RAM index is mem_addr_i[$clog2(DEPTH)+1:2]. Higher RAM addresses alias.
- Reads are combinational from the RAM array or registers. Writes take effect at the rising edge while mem_we_i=1.
- MMIO offsets (address bits [11:0]):
  - 0x000 GPIO: read/write, drives gpio_o.
  - 0x004 COUNT: read/write.
  - 0x008 CMP: read/write.
  - 0x00C CTRL: bit0 EN, bit1 RELOAD, bit2 PEND (write-1-to-clear), bit3 IE. All other bits read 0.
  - Other offsets read 0 and ignore writes.
- Timer, every cycle with EN=1:
  - If COUNT==CMP: PEND<=1. COUNT<=0 if RELOAD=1, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1, wrapping modulo 2^32 from 0xFFFF_FFFF to 0.
- With EN=0, COUNT holds its value and no match is detected.
- irq_o = PEND & IE, taken from registered bits.

## Timing
- Reset values: gpio_o=0, COUNT=0, CMP=0xFFFF_FFFF, CTRL=0, irq_o=0, mem_data_o=decode of the current address over the reset register values.
- RAM contents are not reset.
- Read latency is 0 cycles.
- Write-then-read of the same address returns the new data in the following cycle.
- A software write to COUNT in the same cycle as an increment or reload: the write wins.
- Match and PEND write-1-to-clear in the same cycle: the set wins, so PEND stays 1.
- A write to CTRL that sets IE while PEND=1 raises irq_o on the next cycle.
- A match is detected on the registered COUNT value. irq_o rises 1 cycle after the edge where COUNT==CMP is sampled.
- Asserting rst_i mid-operation immediately returns all registers to their reset values. A write in progress is lost.

## Configuration
- Macro DMEM_MMIO_TIMER_EN.
- Defined: the timer is present as described above.
- Undefined:
  - COUNT, CMP and CTRL are absent and read 0.
  - Writes to them are ignored.
  - irq_o is tied to 0.
  - GPIO and RAM are unaffected.

## Structure
- Shared package dmem_mmio_pkg:
  - offset constants OFS_GPIO, OFS_COUNT, OFS_CMP, OFS_CTRL
  - CTRL bit indices CTRL_EN, CTRL_RELOAD, CTRL_PEND, CTRL_IE
  - CMP reset constant
- One sub-module, mmio_timer: COUNT/CMP/CTRL registers, match logic and irq_o generation. It has a write port for each register and outputs read data for each.
- The top level holds the RAM, the decode logic, the GPIO register and the read mux.

## Test plan
- Reset, then write 0xDEADBEEF to address 0x10 and read 0x10 -> read returns 0xDEADBEEF. A read of 0x13 also returns 0xDEADBEEF because low bits are ignored.
- Aliasing with DEPTH=256: write 0x1 to 0x0, then read 0x400 -> returns 0x1.
- Write 0xA5 to MMIO_BASE+0x000 -> gpio_o=0xA5 on the next cycle. A read of MMIO_BASE+0x010 -> 0.
- Timer:
  - Set CMP=5, then CTRL=0xB (EN, RELOAD, IE) -> COUNT runs 0..5 then returns to 0.
  - PEND=1 and irq_o=1 one cycle after the match.
  - Writing CTRL=0xF (PEND write-1-to-clear) -> irq_o=0 the next cycle, unless a match occurs in the same cycle.
- Set COUNT=0xFFFF_FFFF, CMP=3, EN=1, RELOAD=0 -> COUNT wraps to 0 and PEND is set when COUNT reaches 3.
- Assert rst_i asynchronously mid-count -> COUNT=0, gpio_o=0 and irq_o=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_pkg
// Description : Shared constants and types for the data-memory / MMIO responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_mmio_pkg;

    localparam logic [11:0] OFS_GPIO  = 12'h000;
    localparam logic [11:0] OFS_COUNT = 12'h004;
    localparam logic [11:0] OFS_CMP   = 12'h008;
    localparam logic [11:0] OFS_CTRL  = 12'h00C;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_PEND   = 2;
    localparam int CTRL_IE     = 3;

    localparam logic [31:0] CMP_RST_VAL = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REGION_RAM  = 2'd0,
        REGION_MMIO = 2'd1,
        REGION_NONE = 2'd2
    } region_e;

endpackage : dmem_mmio_pkg
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Compare timer with COUNT/CMP/CTRL registers and interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_timer
    import dmem_mmio_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            count_we,
    input  logic [XLEN-1:0] count_wdata,
    input  logic            cmp_we,
    input  logic [XLEN-1:0] cmp_wdata,
    input  logic            ctrl_we,
    input  logic [3:0]      ctrl_wdata,
    output logic [XLEN-1:0] count_rdata,
    output logic [XLEN-1:0] cmp_rdata,
    output logic [XLEN-1:0] ctrl_rdata,
    output logic            irq_o
);

    logic [XLEN-1:0] r_count;
    logic [XLEN-1:0] r_cmp;
    logic            r_en;
    logic            r_reload;
    logic            r_pend;
    logic            r_ie;
    logic            w_match;

    assign w_match = r_en && (r_count == r_cmp);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count  <= '0;
            r_cmp    <= XLEN'(CMP_RST_VAL);
            r_en     <= 1'b0;
            r_reload <= 1'b0;
            r_pend   <= 1'b0;
            r_ie     <= 1'b0;
        end else begin
            // A software write to COUNT overrides the increment/reload.
            if (count_we) begin
                r_count <= count_wdata;
            end else if (r_en) begin
                r_count <= (w_match && r_reload) ? '0 : r_count + XLEN'(1);
            end
            if (cmp_we) begin
                r_cmp <= cmp_wdata;
            end
            if (ctrl_we) begin
                r_en     <= ctrl_wdata[CTRL_EN];
                r_reload <= ctrl_wdata[CTRL_RELOAD];
                r_ie     <= ctrl_wdata[CTRL_IE];
            end
            // Set beats write-1-to-clear when both land on the same edge.
            if (w_match) begin
                r_pend <= 1'b1;
            end else if (ctrl_we && ctrl_wdata[CTRL_PEND]) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign count_rdata = r_count;
    assign cmp_rdata   = r_cmp;
    assign ctrl_rdata  = {{(XLEN-4){1'b0}}, r_ie, r_pend, r_reload, r_en};
    assign irq_o       = r_pend & r_ie;

endmodule : mmio_timer
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio
// Description : Word RAM plus MMIO window (GPIO, optional compare timer) for
//               the core data port. Timer present when DMEM_MMIO_TIMER_EN set.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 256,
    parameter logic [XLEN-1:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mem_we_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic [XLEN-1:0] mem_data_o,
    output logic [XLEN-1:0] gpio_o,
    output logic            irq_o
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] r_ram [DEPTH];
    logic [XLEN-1:0] r_gpio;
    region_e         w_region;
    logic [AW-1:0]   w_idx;
    logic [11:0]     w_ofs;
    logic            w_mmio_we;
    logic [XLEN-1:0] w_count_rd;
    logic [XLEN-1:0] w_cmp_rd;
    logic [XLEN-1:0] w_ctrl_rd;

    always_comb begin
        w_region = REGION_NONE;
        if (mem_addr_i < MMIO_BASE) begin
            w_region = REGION_RAM;
        end else if (mem_addr_i[XLEN-1:12] == MMIO_BASE[XLEN-1:12]) begin
            w_region = REGION_MMIO;
        end
    end

    assign w_idx     = mem_addr_i[AW+1:2];
    assign w_ofs     = {mem_addr_i[11:2], 2'b00};
    assign w_mmio_we = mem_we_i && (w_region == REGION_MMIO);

    always_ff @(posedge clk_i) begin
        if (mem_we_i && (w_region == REGION_RAM)) begin
            r_ram[w_idx] <= mem_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_gpio <= '0;
        end else if (w_mmio_we && (w_ofs == OFS_GPIO)) begin
            r_gpio <= mem_data_i;
        end
    end

    assign gpio_o = r_gpio;

`ifdef DMEM_MMIO_TIMER_EN
    mmio_timer #(
        .XLEN (XLEN)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .count_we    (w_mmio_we && (w_ofs == OFS_COUNT)),
        .count_wdata (mem_data_i),
        .cmp_we      (w_mmio_we && (w_ofs == OFS_CMP)),
        .cmp_wdata   (mem_data_i),
        .ctrl_we     (w_mmio_we && (w_ofs == OFS_CTRL)),
        .ctrl_wdata  (mem_data_i[3:0]),
        .count_rdata (w_count_rd),
        .cmp_rdata   (w_cmp_rd),
        .ctrl_rdata  (w_ctrl_rd),
        .irq_o       (irq_o)
    );
`else
    assign w_count_rd = '0;
    assign w_cmp_rd   = '0;
    assign w_ctrl_rd  = '0;
    assign irq_o      = 1'b0;
`endif

    always_comb begin
        mem_data_o = '0;
        case (w_region)
            REGION_RAM: mem_data_o = r_ram[w_idx];
            REGION_MMIO: begin
                case (w_ofs)
                    OFS_GPIO:  mem_data_o = r_gpio;
                    OFS_COUNT: mem_data_o = w_count_rd;
                    OFS_CMP:   mem_data_o = w_cmp_rd;
                    OFS_CTRL:  mem_data_o = w_ctrl_rd;
                    default:   mem_data_o = '0;
                endcase
            end
            default: mem_data_o = '0;
        endcase
    end

endmodule : dmem_mmio
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_mmio
// Description : Directed self-checking bench for dmem_mmio (timer checks follow
//               DMEM_MMIO_TIMER_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio;

    localparam logic [31:0] c_base  = 32'h8000_0000;
    localparam logic [31:0] c_gpio  = c_base + 32'h000;
    localparam logic [31:0] c_count = c_base + 32'h004;
    localparam logic [31:0] c_cmp   = c_base + 32'h008;
    localparam logic [31:0] c_ctrl  = c_base + 32'h00C;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] gpio;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    dmem_mmio #(
        .XLEN      (32),
        .DEPTH     (256),
        .MMIO_BASE (c_base)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .mem_we_i   (we),
        .mem_addr_i (addr),
        .mem_data_i (wdata),
        .mem_data_o (rdata),
        .gpio_o     (gpio),
        .irq_o      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Write lands on the next rising edge; returns 1 time unit after it.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        we   = 1'b0;
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = c_gpio;
        wdata = '0;
        #12;
        check("rst_gpio", gpio, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check_read("rst_rd_gpio", c_gpio, 32'h0);
`ifdef DMEM_MMIO_TIMER_EN
        check_read("rst_rd_cmp", c_cmp, 32'hFFFF_FFFF);
        check_read("rst_rd_ctrl", c_ctrl, 32'h0);
`endif
        rst_n = 1'b1;
        tick(1);

        // RAM and aliasing
        do_write(32'h10, 32'hDEAD_BEEF);
        check_read("ram_rd_10", 32'h10, 32'hDEAD_BEEF);
        check_read("ram_rd_13", 32'h13, 32'hDEAD_BEEF);
        do_write(32'h0, 32'h1);
        check_read("ram_alias_400", 32'h400, 32'h1);
        do_write(32'h7FFF_FFFC, 32'h0000_5555);
        check_read("ram_alias_top", 32'h3FC, 32'h0000_5555);
        do_write(32'h9000_0000, 32'h1234_5678);
        check_read("unmapped_rd", 32'h9000_0000, 32'h0);
        check_read("ram_keep_0", 32'h0, 32'h1);

        // GPIO and window decode
        do_write(c_gpio, 32'hA5);
        check("gpio_a5", gpio, 32'hA5);
        check_read("rd_gpio", c_gpio, 32'hA5);
        check_read("rd_ofs10", c_base + 32'h10, 32'h0);
        do_write(c_base + 32'h10, 32'hFFFF_FFFF);
        do_write(32'h8000_1000, 32'hFFFF_FFFF);
        check("gpio_unaffected", gpio, 32'hA5);

`ifdef DMEM_MMIO_TIMER_EN
        // Reload mode: COUNT runs 0..5 then back to 0
        do_write(c_cmp, 32'd5);
        do_write(c_ctrl, 32'hB);
        for (int i = 0; i <= 5; i++) begin
            check_read($sformatf("cnt_%0d", i), c_count, i);
            check($sformatf("irq_lo_%0d", i), {31'b0, irq}, 32'h0);
            tick(1);
        end
        check_read("cnt_reload", c_count, 32'h0);
        check("irq_match", {31'b0, irq}, 32'h1);
        check_read("ctrl_pend", c_ctrl, 32'hF);

        do_write(c_ctrl, 32'hF);
        check("irq_w1c", {31'b0, irq}, 32'h0);
        check_read("ctrl_w1c", c_ctrl, 32'hB);
        check_read("cnt_after_w1c", c_count, 32'h1);
        tick(4);
        check_read("cnt_5_again", c_count, 32'h5);
        do_write(c_ctrl, 32'hF);
        check("irq_set_wins", {31'b0, irq}, 32'h1);
        check_read("cnt_reload2", c_count, 32'h0);

        // Disable with IE off, then re-enable IE while PEND is held
        do_write(c_ctrl, 32'h0);
        check("irq_ie_off", {31'b0, irq}, 32'h0);
        check_read("ctrl_pend_held", c_ctrl, 32'h4);
        check_read("cnt_frozen_a", c_count, 32'h1);
        tick(2);
        check_read("cnt_frozen_b", c_count, 32'h1);
        do_write(c_ctrl, 32'h8);
        check("irq_ie_on", {31'b0, irq}, 32'h1);

        // Free-running wrap, no reload
        do_write(c_ctrl, 32'h4);
        check_read("ctrl_clear", c_ctrl, 32'h0);
        do_write(c_count, 32'hFFFF_FFFF);
        do_write(c_cmp, 32'd3);
        do_write(c_ctrl, 32'h1);
        check_read("wrap_ffff", c_count, 32'hFFFF_FFFF);
        tick(1);
        check_read("wrap_0", c_count, 32'h0);
        tick(3);
        check_read("wrap_3", c_count, 32'h3);
        check_read("wrap_nopend", c_ctrl, 32'h1);
        tick(1);
        check_read("wrap_4", c_count, 32'h4);
        check_read("wrap_pend", c_ctrl, 32'h5);

        do_write(c_count, 32'd100);
        check_read("cnt_write_wins", c_count, 32'd100);

        do_write(c_ctrl, 32'h9);
        check("irq_pre_rst", {31'b0, irq}, 32'h1);
`else
        do_write(c_count, 32'h5);
        do_write(c_cmp, 32'h5);
        do_write(c_ctrl, 32'hF);
        check_read("notmr_count", c_count, 32'h0);
        check_read("notmr_cmp", c_cmp, 32'h0);
        check_read("notmr_ctrl", c_ctrl, 32'h0);
        tick(8);
        check("notmr_irq", {31'b0, irq}, 32'h0);
`endif

        // Asynchronous reset mid-cycle, no clock edge in between
        do_write(c_gpio, 32'h5A);
        check("gpio_5a", gpio, 32'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gpio", gpio, 32'h0);
        check("arst_irq", {31'b0, irq}, 32'h0);
        check_read("arst_rd_count", c_count, 32'h0);
        check_read("arst_ram_kept", 32'h10, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dmem_mmio
`default_nettype wire
